// File: rtl/delay_int16_arbiter.sv
// delay_int16_arbiter: round-robin share of one fixed-latency delay pipe among NREQ requesters.
// Ports: clock; reset (async, active-low); flush (only with DELAY_ARB_FLUSH_EN, sync, active-high);
//   req_valid/req_data/req_ready per-requester handshake; rsp_valid one-hot return strobe;
//   rsp_data shared return word; busy any word in flight.
module delay_int16_arbiter #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 4,
  parameter int NREQ    = 4,
  parameter int CREDITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef DELAY_ARB_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);
  localparam int TW = $clog2(NREQ);
  localparam int CW = $clog2(CREDITS + 1);
  logic fl;
`ifdef DELAY_ARB_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  logic [CW-1:0]    credit [NREQ];
  logic [TW-1:0]    ptr, gidx;
  logic             found;
  logic [NREQ-1:0]  elig, ret;
  logic [LATENCY-1:0] sv;
  logic [TW-1:0]    st [LATENCY];
  logic [WIDTH-1:0] sd [LATENCY];
  // Grants are suppressed while reset is held so no word is lost into a cleared pipe.
  always_comb begin
    elig = '0;
    ret = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = reset & ~fl & req_valid[i] & (credit[i] < CW'(CREDITS));
      ret[i] = sv[LATENCY-1] & (st[LATENCY-1] == TW'(i));
    end
  end
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int k = 0; k < NREQ; k++)
      if (!found && elig[TW'((int'(ptr) + k) % NREQ)]) begin
        found = 1'b1;
        gidx = TW'((int'(ptr) + k) % NREQ);
      end
  end
  assign req_ready = found ? NREQ'(1) << gidx : '0;
  // The last stage register is the output register: rsp_valid is its decoded tag,
  // rsp_data its data, which only reloads when a valid word enters it.
  assign rsp_valid = ret;
  assign rsp_data  = sd[LATENCY-1];
  assign busy      = |sv;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sv <= '0;
      for (int j = 0; j < LATENCY; j++) begin
        st[j] <= '0;
        sd[j] <= '0;
      end
    end else begin
      sv[0] <= found;
      st[0] <= gidx;
      if (found) sd[0] <= req_data[gidx*WIDTH +: WIDTH];
      for (int j = 1; j < LATENCY; j++) begin
        sv[j] <= sv[j-1];
        st[j] <= st[j-1];
        if (sv[j-1]) sd[j] <= sd[j-1];
      end
      if (fl) sv <= '0;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset || fl) begin
      ptr <= '0;
      for (int i = 0; i < NREQ; i++) credit[i] <= '0;
    end else begin
      if (found) ptr <= (gidx == TW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      for (int i = 0; i < NREQ; i++)
        credit[i] <= credit[i] + CW'(found && gidx == TW'(i)) - CW'(ret[i]);
    end
  end
endmodule

// File: tb/tb_delay_int16_arbiter.sv
// tb_delay_int16_arbiter: randomized and directed check against a transaction-level model.
module tb_delay_int16_arbiter;
  localparam int W = 16, LAT = 4, NR = 4, CRED = 2;
  logic clock = 1'b0, reset = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*W-1:0] req_data = '0;
  logic [NR-1:0] req_ready, rsp_valid;
  logic [W-1:0] rsp_data;
  logic busy;
`ifdef DELAY_ARB_FLUSH_EN
  logic flush = 1'b0;
`endif
  delay_int16_arbiter #(.WIDTH(W), .LATENCY(LAT), .NREQ(NR), .CREDITS(CRED)) dut (
    .clock(clock),
    .reset(reset),
`ifdef DELAY_ARB_FLUSH_EN
    .flush(flush),
`endif
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .busy(busy)
  );
  initial forever #5 clock = ~clock;
  typedef struct {int tag; logic [W-1:0] d; int vis;} ent_t;
  ent_t q[$];
  int cred[NR];
  int ptr_m = 0, cyc = 0, n_cmp = 0, n_bad = 0;
  logic [W-1:0] last = '0;
  bit pend[NR];
  logic [W-1:0] pdata[NR];
  task automatic gen(input int prob, input logic [NR-1:0] mask);
    for (int i = 0; i < NR; i++)
      if (mask[i] && !pend[i] && $urandom_range(99) < prob) begin
        pend[i] = 1'b1;
        pdata[i] = W'($urandom);
      end
  endtask
  task automatic step(input bit rv, input bit fv);
    int eg;
    logic [NR-1:0] er, ev;
    @(negedge clock);
    reset = rv;
`ifdef DELAY_ARB_FLUSH_EN
    flush = fv;
`endif
    for (int j = 0; j < NR; j++) begin
      req_valid[j] = pend[j];
      req_data[j*W +: W] = pdata[j];
    end
    if (!rv) begin
      q.delete();
      for (int j = 0; j < NR; j++) cred[j] = 0;
      ptr_m = 0;
      last = '0;
    end
    #1;
    eg = -1;
    if (rv && !fv)
      for (int k = 0; k < NR; k++)
        if (eg < 0 && pend[(ptr_m + k) % NR] && cred[(ptr_m + k) % NR] < CRED) eg = (ptr_m + k) % NR;
    er = (eg < 0) ? '0 : NR'(1) << eg;
    ev = '0;
    foreach (q[j])
      if (q[j].vis == cyc) begin
        ev[q[j].tag] = 1'b1;
        last = q[j].d;
      end
    n_cmp++;
    assert (req_ready === er) else begin n_bad++; $error("FAIL ready c%0d: got %b expected %b", cyc, req_ready, er); end
    n_cmp++;
    assert (rsp_valid === ev) else begin n_bad++; $error("FAIL rsp_valid c%0d: got %b expected %b", cyc, rsp_valid, ev); end
    n_cmp++;
    assert (rsp_data === last) else begin n_bad++; $error("FAIL rsp_data c%0d: got %h expected %h", cyc, rsp_data, last); end
    n_cmp++;
    assert (busy === (q.size() > 0)) else begin n_bad++; $error("FAIL busy c%0d: got %b expected %b", cyc, busy, q.size() > 0); end
    @(posedge clock);
    cyc++;
    if (rv) begin
      for (int j = q.size() - 1; j >= 0; j--)
        if (q[j].vis < cyc) begin
          cred[q[j].tag]--;
          q.delete(j);
        end
      if (fv) begin
        q.delete();
        for (int j = 0; j < NR; j++) cred[j] = 0;
        ptr_m = 0;
      end else if (eg >= 0) begin
        cred[eg]++;
        q.push_back('{eg, pdata[eg], cyc + LAT - 1});
        pend[eg] = 1'b0;
        ptr_m = (eg + 1) % NR;
      end
    end
  endtask
  initial begin
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      pdata[i] = '0;
      cred[i] = 0;
    end
    repeat (3) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    pend[2] = 1'b1;
    pdata[2] = 16'h1234;
    repeat (8) step(1'b1, 1'b0);
    repeat (30) begin gen(100, 4'hF); step(1'b1, 1'b0); end
    repeat (6) step(1'b1, 1'b0);
    repeat (16) begin gen(100, 4'b0001); step(1'b1, 1'b0); end
    repeat (6) step(1'b1, 1'b0);
    repeat (3) begin gen(100, 4'hF); step(1'b1, 1'b0); end
    repeat (2) step(1'b0, 1'b0);
    gen(100, 4'b1010);
    repeat (10) begin gen(100, 4'hF); step(1'b1, 1'b0); end
    repeat (600) begin
      gen($urandom_range(100), NR'($urandom));
      step(($urandom_range(199) != 0), 1'b0);
    end
`ifdef DELAY_ARB_FLUSH_EN
    repeat (8) step(1'b1, 1'b0);
    repeat (4) begin gen(100, 4'hF); step(1'b1, 1'b0); end
    step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    gen(100, 4'b0100);
    repeat (8) step(1'b1, 1'b0);
`endif
    repeat (10) step(1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
